frame_buf_ring: RTL and testbench
=================================

Name: frame_buf_ring

Overview:
Single-clock, N-deep frame buffer that generalises the one-frame fill/read buffer to a ring of NUM_BUFS frame slots. A writer fills one slot while the reader drains the oldest completed slot, so frames are delivered strictly in order. Frame alignment is explicit via a start-of-frame flag. When no slot is free, frames are dropped and reported. Sits between a pixel/sample producer and a consumer in the same clock domain.

Parameters:
DATA_WIDTH, 32, word width
ADDR_WIDTH, 3, log2 of words per frame (FRAME_WORDS = 1 << ADDR_WIDTH)
NUM_BUFS, 2, number of frame slots, >= 2, need not be a power of two
BUF_IDX_WIDTH, 1, width of slot index, must hold NUM_BUFS-1
CNT_WIDTH, 2, width of frame count, must hold NUM_BUFS

Ports:
clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
wr_en_in  in  1  active-low write strobe, one word per asserted cycle
wr_sof  in  1  active-high, marks word 0 of a frame; qualified by wr_en_in
data_in  in  DATA_WIDTH  write word
rd_en_in  in  1  active-low read strobe, one word issued per asserted cycle
data_out  out  DATA_WIDTH  read word
rd_data_valid  out  1  data_out valid
rd_eof  out  1  high with the last word of a frame
rd_rdy  out  1  an unread completed frame exists
frame_cnt  out  CNT_WIDTH  completed frames not yet released
wr_full  out  1  frame_cnt == NUM_BUFS
wr_drop  out  1  one-cycle pulse per discarded word
wr_err  out  1  one-cycle pulse on sof received mid-frame
drop_cnt  out  16  dropped-frame counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0, both FSMs IDLE, wr_idx = rd_idx = 0, word addresses 0, frame_cnt 0. Memory contents not cleared. Reset mid-operation abandons the partial write and the in-progress read; no rd_data_valid the cycle after reset.
- Physical address = {slot_idx, word_addr}. Memory depth = NUM_BUFS * FRAME_WORDS.
- Slot indices wrap explicitly from NUM_BUFS-1 to 0.
- Writer FSM: IDLE, FILL.
  - IDLE: a word is accepted only if wr_en_in is low, wr_sof is 1, and frame_cnt < NUM_BUFS. It is written to word 0 of slot wr_idx and the FSM goes to FILL with word_addr = 1.
  - IDLE, word strobed without sof: word discarded, wr_drop pulses.
  - IDLE, sof strobed with wr_full = 1: word discarded, wr_drop pulses, drop-frame flag set. All words until the next sof are discarded, each pulsing wr_drop.
  - FILL: each strobe writes at word_addr and increments it. The strobe carrying word FRAME_WORDS-1 completes the frame: frame_cnt is incremented, wr_idx advances, and the FSM returns to IDLE.
  - FILL, sof strobed: wr_err pulses; that word is written to word 0 of the same slot and word_addr = 1 (frame restart).
  - Cycles without a strobe hold state.
- Reader FSM: IDLE, READ.
  - rd_rdy = frame_cnt > (rd_state == READ).
  - IDLE: rd_en_in low with rd_rdy = 1 issues a read of word 0 of slot rd_idx and the FSM goes to READ with word_addr = 1. rd_en_in low with rd_rdy = 0 is ignored.
  - READ: each strobe issues the next word.
  - Issue of word FRAME_WORDS-1 releases the slot: frame_cnt is decremented, rd_idx advances, and the FSM returns to IDLE.
  - Read latency is 1 cycle: data_out, rd_data_valid and rd_eof are registered one cycle after issue. data_out holds its last value when not valid.
- Simultaneous frame completion and slot release: frame_cnt unchanged. wr_full is computed from the registered count. A slot released in cycle N is writable from cycle N+1.
- The writer never targets rd_idx while that slot is counted in frame_cnt. This is guaranteed by the count check, not by an extra comparison.

Optional Feature:
FRAME_BUF_RING_STATS_EN
- Defined: drop_cnt increments by 1 per dropped frame (on the discarded sof strobe only) and saturates at 0xFFFF. It is cleared by reset.
- Undefined: drop_cnt is tied to 0; no counter logic is generated. All other behaviour is identical.

Decomposition:
- Shared header frame_buf_defs.vh:
  - ASSERT_L/DEASSERT_L and ASSERT_H/DEASSERT_H defines
  - writer state encodings W_IDLE, W_FILL
  - reader state encodings R_IDLE, R_READ
- One sub-module, frame_buf_ring_mem: simple dual-port memory, single clock, registered 1-cycle read with a valid flag, parametrised by DATA_WIDTH and total address width.
- The top level holds both FSMs, the ring indices, the count and the stats.

Test Plan:
(All scenarios use NUM_BUFS=2, ADDR_WIDTH=3.)
1. Assert reset for 2 cycles -> all outputs 0, rd_rdy 0, frame_cnt 0.
2. Write 8 words 0x10..0x17 (sof on 0x10), then strobe read 8 cycles -> frame_cnt = 1 the cycle after 0x17. data_out is 0x10..0x17 with rd_data_valid one cycle after each issue. rd_eof on 0x17. frame_cnt returns to 0.
3. Write 2 frames, no reads, then a third 8-word frame -> wr_full = 1, wr_drop pulses 8 times, frame_cnt stays 2. With the macro, drop_cnt = 1. The reader then returns the first two frames in order.
4. Reader issues the last word of frame A in the same cycle the writer writes the last word of frame C -> frame_cnt unchanged, rd_rdy stays 1.
5. Raise sof at word 4 of a frame, then write 8 words 0xA0..0xA7 -> wr_err pulses once; the read returns 0xA0..0xA7.
6. Assert reset on the 3rd cycle of a read burst -> rd_data_valid 0 from the next cycle, frame_cnt 0, rd_rdy 0. A new frame then writes and reads correctly from slot 0.

Source files
------------

// File: rtl/frame_buf_ring_pkg.sv
// Shared definitions for the frame_buf_ring slice: strobe polarities,
// writer/reader state encodings and the FSM debug struct.
package frame_buf_ring_pkg;

  // Strobe polarities. The word strobes are active-low and the flags are active-high.
  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  // Writer FSM states.
  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } w_state_t;

  // Reader FSM states.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } r_state_t;

  // Both FSM states, exported on the debug port.
  typedef struct packed {
    w_state_t w_state;
    r_state_t r_state;
  } fsm_dbg_t;

endpackage

// File: rtl/frame_buf_ring_mem.sv
// Simple dual-port frame memory: one write port and one registered read port
// with 1-cycle latency. The array itself is never reset. Only the read data
// and valid registers are cleared.
module frame_buf_ring_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: register the word one cycle after issue. rdata holds its value while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/frame_buf_ring.sv
// frame_buf_ring: ring of NUM_BUFS frame slots between a producer and a
// consumer in one clock domain. The writer fills slot wr_idx while the reader
// drains the oldest completed slot rd_idx, so frames leave in arrival order.
// The optional dropped-frame counter is enabled by defining FRAME_BUF_RING_STATS_EN.
//
// Handshake: wr_en_in and rd_en_in are active-low strobes with no back-pressure.
// Each low cycle moves exactly one word, and there is no ready signal.
// A write strobe is accepted or discarded in the same cycle, and a discard is
// flagged on wr_drop in the next cycle.
// A read strobe issues a word only while a read is in progress or rd_rdy is high.
// Each issued word appears on data_out with rd_data_valid one cycle later.
module frame_buf_ring
  import frame_buf_ring_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 3,
  parameter int NUM_BUFS      = 2,
  parameter int BUF_IDX_WIDTH = 1,
  parameter int CNT_WIDTH     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_in,
  input  logic                  wr_sof,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_data_valid,
  output logic                  rd_eof,
  output logic                  rd_rdy,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  wr_full,
  output logic                  wr_drop,
  output logic                  wr_err,
  output logic [15:0]           drop_cnt,
  output fsm_dbg_t              dbg
);

  localparam int FRAME_WORDS = 1 << ADDR_WIDTH;
  localparam int PHYS_WIDTH  = BUF_IDX_WIDTH + ADDR_WIDTH;
  localparam int MEM_DEPTH   = NUM_BUFS * FRAME_WORDS;
  localparam logic [ADDR_WIDTH-1:0]    LAST_WORD = ADDR_WIDTH'(FRAME_WORDS - 1);
  localparam logic [BUF_IDX_WIDTH-1:0] LAST_IDX  = BUF_IDX_WIDTH'(NUM_BUFS - 1);
  localparam logic [CNT_WIDTH-1:0]     CNT_FULL  = CNT_WIDTH'(NUM_BUFS);

  w_state_t                 w_state;
  r_state_t                 r_state;
  logic [BUF_IDX_WIDTH-1:0] wr_idx;
  logic [BUF_IDX_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0]    w_addr;
  logic [ADDR_WIDTH-1:0]    r_addr;

  logic                     wr_strobe;
  logic                     rd_strobe;
  logic                     mem_we;
  logic [PHYS_WIDTH-1:0]    mem_waddr;
  logic                     mem_re;
  logic [PHYS_WIDTH-1:0]    mem_raddr;
  logic                     frame_done;
  logic                     frame_release;
  logic                     drop_word;
  logic                     sof_err;
  logic                     reading;

  // Slot indices wrap explicitly, because NUM_BUFS need not be a power of two.
  function automatic logic [BUF_IDX_WIDTH-1:0] next_idx(input logic [BUF_IDX_WIDTH-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + BUF_IDX_WIDTH'(1);
  endfunction

  // During reset the strobes are masked, so the memory is not touched.
  assign wr_strobe = (wr_en_in == ASSERT_L) && (reset == DEASSERT_H);
  assign rd_strobe = (rd_en_in == ASSERT_L) && (reset == DEASSERT_H);

  // wr_full comes from the registered count.
  // A slot released this cycle therefore becomes writable in the next cycle.
  assign wr_full = (frame_cnt == CNT_FULL);
  assign reading = (r_state == R_READ);
  // A frame being drained does not count as an unread frame.
  assign rd_rdy  = (frame_cnt > {{(CNT_WIDTH-1){1'b0}}, reading});
  assign dbg     = '{w_state: w_state, r_state: r_state};

  // Writer decode: decide whether to write, discard or restart, and whether this word completes a frame.
  always_comb begin
    mem_we     = 1'b0;
    mem_waddr  = {wr_idx, {ADDR_WIDTH{1'b0}}};
    frame_done = 1'b0;
    drop_word  = 1'b0;
    sof_err    = 1'b0;
    if (wr_strobe) begin
      unique case (w_state)
        W_IDLE: begin
          // Only an sof word with a free slot opens a frame. Every other word is discarded.
          if ((wr_sof == ASSERT_H) && !wr_full) begin
            mem_we = 1'b1;
          end else begin
            drop_word = 1'b1;
          end
        end
        W_FILL: begin
          mem_we = 1'b1;
          if (wr_sof == ASSERT_H) begin
            // An sof received mid-frame restarts the same slot at word 0.
            sof_err = 1'b1;
          end else begin
            mem_waddr  = {wr_idx, w_addr};
            frame_done = (w_addr == LAST_WORD);
          end
        end
        default: ;
      endcase
    end
  end

  // Reader decode: issue a word while a read is in progress, or start a new frame when one is ready.
  always_comb begin
    mem_re        = rd_strobe && (reading || rd_rdy);
    mem_raddr     = {rd_idx, reading ? r_addr : {ADDR_WIDTH{1'b0}}};
    frame_release = mem_re && reading && (r_addr == LAST_WORD);
  end

  // Writer FSM, slot index and registered write-side pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      wr_idx  <= '0;
      wr_drop <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      wr_drop <= drop_word;
      wr_err  <= sof_err;
      if (wr_strobe) begin
        unique case (w_state)
          W_IDLE: begin
            if (mem_we) begin
              w_state <= W_FILL;
              w_addr  <= ADDR_WIDTH'(1);
            end
          end
          W_FILL: begin
            if (wr_sof == ASSERT_H) begin
              w_addr <= ADDR_WIDTH'(1);
            end else if (frame_done) begin
              w_state <= W_IDLE;
              w_addr  <= '0;
              wr_idx  <= next_idx(wr_idx);
            end else begin
              w_addr <= w_addr + ADDR_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Reader FSM, slot index and end-of-frame flag aligned with the read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      rd_idx  <= '0;
      rd_eof  <= 1'b0;
    end else begin
      rd_eof <= frame_release;
      if (mem_re) begin
        unique case (r_state)
          R_IDLE: begin
            r_state <= R_READ;
            r_addr  <= ADDR_WIDTH'(1);
          end
          R_READ: begin
            if (frame_release) begin
              r_state <= R_IDLE;
              r_addr  <= '0;
              rd_idx  <= next_idx(rd_idx);
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Completed-frame count. When a frame completes and a slot is released in the same cycle, the count is unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else begin
      unique case ({frame_done, frame_release})
        2'b10:   frame_cnt <= frame_cnt + CNT_WIDTH'(1);
        2'b01:   frame_cnt <= frame_cnt - CNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

`ifdef FRAME_BUF_RING_STATS_EN
  logic        drop_sof;
  logic [15:0] drop_cnt_q;

  // A dropped frame is counted once, on its discarded sof word.
  assign drop_sof = wr_strobe && (w_state == W_IDLE) && (wr_sof == ASSERT_H) && wr_full;

  // Saturating dropped-frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop_sof && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  frame_buf_ring_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PHYS_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wdata  (data_in),
    .re     (mem_re),
    .raddr  (mem_raddr),
    .rdata  (data_out),
    .rvalid (rd_data_valid)
  );

endmodule

// File: tb/tb_frame_buf_ring.sv
// Testbench for frame_buf_ring. The reference model tracks whole frames as
// word queues: the partial frame, the completed words and a read cursor.
// It does not track slots or addresses.
module tb_frame_buf_ring;
  import frame_buf_ring_pkg::*;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NB = 2;
  localparam int IW = 1;
  localparam int CW = 2;
  localparam int FW = 1 << AW;

  // ---------------- clock / reset ----------------
  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          wr_en_in = 1'b1;
  logic          wr_sof   = 1'b0;
  logic [DW-1:0] data_in  = '0;
  logic          rd_en_in = 1'b1;
  logic [DW-1:0] data_out;
  logic          rd_data_valid;
  logic          rd_eof;
  logic          rd_rdy;
  logic [CW-1:0] frame_cnt;
  logic          wr_full;
  logic          wr_drop;
  logic          wr_err;
  logic [15:0]   drop_cnt;
  fsm_dbg_t      dbg;

  always #5 clk = ~clk;

  frame_buf_ring #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .NUM_BUFS      (NB),
    .BUF_IDX_WIDTH (IW),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en_in      (wr_en_in),
    .wr_sof        (wr_sof),
    .data_in       (data_in),
    .rd_en_in      (rd_en_in),
    .data_out      (data_out),
    .rd_data_valid (rd_data_valid),
    .rd_eof        (rd_eof),
    .rd_rdy        (rd_rdy),
    .frame_cnt     (frame_cnt),
    .wr_full       (wr_full),
    .wr_drop       (wr_drop),
    .wr_err        (wr_err),
    .drop_cnt      (drop_cnt),
    .dbg           (dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] word_q[$];   // words of completed, unreleased frames in order
  logic [DW-1:0] part_q[$];   // frame currently being filled
  bit            m_fill;
  int            m_cnt;
  bit            m_in_read;
  int            m_rpos;
  logic [DW-1:0] m_dout;
  bit            m_valid, m_eof, m_drop, m_err;
  int            m_drops;
  bit            m_done, m_rel;

  always @(posedge clk) begin
    if (reset) begin
      word_q.delete(); part_q.delete();
      m_fill = 0; m_cnt = 0; m_in_read = 0; m_rpos = 0;
      m_dout = '0; m_valid = 0; m_eof = 0; m_drop = 0; m_err = 0; m_drops = 0;
    end else begin
      m_done = 0; m_rel = 0;
      m_valid = 0; m_eof = 0; m_drop = 0; m_err = 0;
      // reader works on the count as it was before this edge
      if (!rd_en_in && (m_in_read || m_cnt > 0)) begin
        m_dout = word_q.pop_front();
        m_valid = 1; m_in_read = 1; m_rpos++;
        if (m_rpos == FW) begin
          m_eof = 1; m_rel = 1; m_in_read = 0; m_rpos = 0;
        end
      end
      if (!wr_en_in) begin
        if (!m_fill) begin
          if (wr_sof && m_cnt < NB) begin
            part_q.delete(); part_q.push_back(data_in); m_fill = 1;
          end else begin
            m_drop = 1;
            if (wr_sof && m_drops < 65535) m_drops++;
          end
        end else if (wr_sof) begin
          m_err = 1; part_q.delete(); part_q.push_back(data_in);
        end else begin
          part_q.push_back(data_in);
          if (part_q.size() == FW) begin
            foreach (part_q[i]) word_q.push_back(part_q[i]);
            part_q.delete(); m_fill = 0; m_done = 1;
          end
        end
      end
      m_cnt = m_cnt + int'(m_done) - int'(m_rel);
    end
  end

  function automatic int exp_drop_cnt();
`ifdef FRAME_BUF_RING_STATS_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] rd_log[$];
  logic [DW-1:0] exp_q[$];
  int drop_pulses = 0;
  int err_pulses  = 0;
  int eof_pulses  = 0;

  always @(negedge clk) begin
    if (check_en) begin
      cmp("data_out", data_out, m_dout);
      cmp("rd_data_valid", 32'(rd_data_valid), 32'(m_valid));
      cmp("rd_eof", 32'(rd_eof), 32'(m_eof));
      cmp("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      cmp("rd_rdy", 32'(rd_rdy), 32'(m_cnt > int'(m_in_read)));
      cmp("wr_full", 32'(wr_full), 32'(m_cnt == NB));
      cmp("wr_drop", 32'(wr_drop), 32'(m_drop));
      cmp("wr_err", 32'(wr_err), 32'(m_err));
      cmp("drop_cnt", 32'(drop_cnt), 32'(exp_drop_cnt()));
      cmp("dbg_w_fill", 32'(dbg.w_state == W_FILL), 32'(m_fill));
      cmp("dbg_r_read", 32'(dbg.r_state == R_READ), 32'(m_in_read));
      if (rd_data_valid) rd_log.push_back(data_out);
      if (wr_drop) drop_pulses++;
      if (wr_err) err_pulses++;
      if (rd_eof) eof_pulses++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en_in = 1'b0;
      wr_sof   = (i == 0);
      data_in  = base + DW'(i);
      tick();
    end
    wr_en_in = 1'b1;
    wr_sof   = 1'b0;
  endtask

  task automatic read_n(input int n);
    rd_en_in = 1'b0;
    repeat (n) tick();
    rd_en_in = 1'b1;
  endtask

  task automatic exp_frame(input logic [DW-1:0] base);
    for (int i = 0; i < FW; i++) exp_q.push_back(base + DW'(i));
  endtask

  // Compare the logged read words against exp_q, then clear both.
  task automatic check_log(input string nm);
    cmp({nm, "_len"}, 32'(rd_log.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rd_log.size() > 0) cmp(nm, rd_log.pop_front(), exp_q.pop_front());
    exp_q.delete();
    rd_log.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1. reset for two cycles
    reset = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    cmp("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    cmp("rst_rd_rdy", 32'(rd_rdy), 32'd0);
    cmp("rst_valid", 32'(rd_data_valid), 32'd0);
    cmp("rst_data_out", data_out, 32'd0);
    cmp("rst_flags", 32'({rd_eof, wr_full, wr_drop, wr_err}), 32'd0);
    cmp("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // 2. single frame through
    write_words(32'h10, FW);
    cmp("sc2_frame_cnt_after_fill", 32'(frame_cnt), 32'd1);
    cmp("sc2_rd_rdy", 32'(rd_rdy), 32'd1);
    eof_pulses = 0;
    read_n(FW);
    tick(); tick();
    exp_frame(32'h10);
    check_log("sc2_read");
    cmp("sc2_eof_pulses", 32'(eof_pulses), 32'd1);
    cmp("sc2_frame_cnt_after_read", 32'(frame_cnt), 32'd0);

    // 3. fill both slots, drop the third frame, then drain in order
    write_words(32'h20, FW);
    write_words(32'h30, FW);
    cmp("sc3_wr_full", 32'(wr_full), 32'd1);
    drop_pulses = 0;
    write_words(32'h40, FW);
    tick();
    cmp("sc3_drop_pulses", 32'(drop_pulses), 32'd8);
    cmp("sc3_frame_cnt", 32'(frame_cnt), 32'd2);
`ifdef FRAME_BUF_RING_STATS_EN
    cmp("sc3_drop_cnt", 32'(drop_cnt), 32'd1);
`else
    cmp("sc3_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    read_n(2 * FW);
    tick(); tick();
    exp_frame(32'h20);
    exp_frame(32'h30);
    check_log("sc3_read");

    // 4. the last read issue and the last write land in the same cycle
    write_words(32'h50, FW);
    for (int i = 0; i < FW; i++) begin
      wr_en_in = 1'b0;
      wr_sof   = (i == 0);
      data_in  = 32'h60 + DW'(i);
      rd_en_in = 1'b0;
      tick();
    end
    wr_en_in = 1'b1; wr_sof = 1'b0; rd_en_in = 1'b1;
    cmp("sc4_frame_cnt", 32'(frame_cnt), 32'd1);
    cmp("sc4_rd_rdy", 32'(rd_rdy), 32'd1);
    read_n(FW);
    tick(); tick();
    exp_frame(32'h50);
    exp_frame(32'h60);
    check_log("sc4_read");

    // 5. sof arrives at word 4 and restarts the frame
    err_pulses = 0;
    write_words(32'h90, 4);
    write_words(32'hA0, FW);
    tick();
    cmp("sc5_err_pulses", 32'(err_pulses), 32'd1);
    cmp("sc5_frame_cnt", 32'(frame_cnt), 32'd1);
    read_n(FW);
    tick(); tick();
    exp_frame(32'hA0);
    check_log("sc5_read");

    // 6. reset on the third cycle of a read burst
    write_words(32'hB0, FW);
    rd_en_in = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    cmp("sc6_valid", 32'(rd_data_valid), 32'd0);
    cmp("sc6_frame_cnt", 32'(frame_cnt), 32'd0);
    cmp("sc6_rd_rdy", 32'(rd_rdy), 32'd0);
    reset = 1'b0;
    rd_en_in = 1'b1;
    tick();
    cmp("sc6_valid_after", 32'(rd_data_valid), 32'd0);
    rd_log.delete();
    write_words(32'hC0, FW);
    read_n(FW);
    tick(); tick();
    exp_frame(32'hC0);
    check_log("sc6_read");

    // 7. randomized traffic, including mid-frame sof, drops and occasional reset
    for (int c = 0; c < 3000; c++) begin
      wr_en_in = ($urandom_range(0, 3) == 0);
      wr_sof   = ($urandom_range(0, 9) == 0);
      data_in  = $urandom;
      rd_en_in = ($urandom_range(0, 1) == 0);
      reset    = ($urandom_range(0, 599) == 0);
      tick();
    end
    wr_en_in = 1'b1; wr_sof = 1'b0; rd_en_in = 1'b1; reset = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
